// File: rtl/obi_uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : obi_uart_pkg
// Brief    : Shared OBI channel types, debug-bridge FSM states, opcodes and status codes.
// Revision : 1.0
// ----------------------------------------------------------------------------
package obi_uart_pkg;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiIdWidth   = 1;

  typedef struct packed {
    logic [ObiAddrWidth-1:0]   addr;
    logic                      we;
    logic [ObiDataWidth/8-1:0] be;
    logic [ObiDataWidth-1:0]   wdata;
    logic [ObiIdWidth-1:0]     aid;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic                    err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  typedef enum logic [2:0] {
    DBG_IDLE    = 3'd0,
    DBG_ADDR    = 3'd1,
    DBG_DATA    = 3'd2,
    DBG_REQ     = 3'd3,
    DBG_RSP     = 3'd4,
    DBG_TX_STAT = 3'd5,
    DBG_TX_DATA = 3'd6
  } dbg_state_e;

  localparam logic [7:0] DbgOpWrite    = 8'h01;
  localparam logic [7:0] DbgOpRead     = 8'h02;
  localparam logic [7:0] DbgStsOk      = 8'hA5;
  localparam logic [7:0] DbgStsErr     = 8'hE1;
  localparam logic [7:0] DbgStsBadOp   = 8'hE0;
  localparam logic [7:0] DbgStsTimeout = 8'hE3;

  function automatic logic [7:0] dbg_byte_sel(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/obi_uart_dbg_mgr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : obi_uart_dbg_mgr
// Brief    : UART byte-command to OBI manager bridge, one transaction in flight.
//            Define OBI_UART_DBG_TIMEOUT_EN to abort stalled frames after IdleTimeout.
// Revision : 1.0
// ----------------------------------------------------------------------------
module obi_uart_dbg_mgr #(
  parameter type obi_req_t = obi_uart_pkg::obi_req_t,
  parameter type obi_rsp_t = obi_uart_pkg::obi_rsp_t,
  parameter logic [obi_uart_pkg::ObiIdWidth-1:0] ObiId = '0,
  parameter int unsigned IdleTimeout = 100_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output obi_req_t   obi_req_o,
  input  obi_rsp_t   obi_rsp_i,
  output logic       busy_o
);
  import obi_uart_pkg::*;

  dbg_state_e  r_state, w_state_nxt;
  logic [1:0]  r_cnt;
  logic        r_is_write;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [7:0]  r_status;
  logic        w_rx_hs, w_tx_hs, w_tmo, w_in_field;
  logic [7:0]  w_addr_byte;

  assign w_in_field = (r_state == DBG_ADDR) || (r_state == DBG_DATA);
  assign rx_ready_o = (r_state == DBG_IDLE) || w_in_field;
  assign tx_valid_o = (r_state == DBG_TX_STAT) || (r_state == DBG_TX_DATA);
  assign busy_o     = (r_state != DBG_IDLE);
  assign w_rx_hs    = rx_valid_i & rx_ready_o;
  assign w_tx_hs    = tx_valid_o & tx_ready_i;
  // The two address LSBs are dropped on capture so the bus address is always word aligned.
  assign w_addr_byte = (r_cnt == 2'd0) ? {rx_data_i[7:2], 2'b00} : rx_data_i;

`ifdef OBI_UART_DBG_TIMEOUT_EN
  localparam int unsigned TmoW = (IdleTimeout > 2) ? $clog2(IdleTimeout) : 1;
  logic [TmoW-1:0] r_tmo;

  always_ff @(posedge clk_i) begin
    if (rst_i || w_rx_hs || !w_in_field) r_tmo <= '0;
    else                                 r_tmo <= r_tmo + 1'b1;
  end

  assign w_tmo = w_in_field && !w_rx_hs && (r_tmo == TmoW'(IdleTimeout - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= DBG_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    tx_data_o   = r_status;
    obi_req_o   = '0;
    obi_req_o.a.addr  = r_addr;
    obi_req_o.a.we    = r_is_write;
    obi_req_o.a.be    = r_is_write ? 4'hF : 4'h0;
    obi_req_o.a.wdata = r_wdata;
    obi_req_o.a.aid   = ObiId;
    obi_req_o.req     = (r_state == DBG_REQ);
    obi_req_o.rready  = 1'b1;
    case (r_state)
      DBG_IDLE: if (w_rx_hs) begin
        w_state_nxt = ((rx_data_i == DbgOpWrite) || (rx_data_i == DbgOpRead)) ? DBG_ADDR : DBG_TX_STAT;
      end
      DBG_ADDR: if (w_tmo) w_state_nxt = DBG_TX_STAT;
                else if (w_rx_hs && r_cnt == 2'd3) w_state_nxt = r_is_write ? DBG_DATA : DBG_REQ;
      DBG_DATA: if (w_tmo) w_state_nxt = DBG_TX_STAT;
                else if (w_rx_hs && r_cnt == 2'd3) w_state_nxt = DBG_REQ;
      DBG_REQ:  if (obi_rsp_i.gnt) w_state_nxt = DBG_RSP;
      DBG_RSP:  if (obi_rsp_i.rvalid) w_state_nxt = DBG_TX_STAT;
      DBG_TX_STAT: if (w_tx_hs) begin
        w_state_nxt = (!r_is_write && r_status == DbgStsOk) ? DBG_TX_DATA : DBG_IDLE;
      end
      DBG_TX_DATA: begin
        tx_data_o = dbg_byte_sel(r_rdata, r_cnt);
        if (w_tx_hs && r_cnt == 2'd3) w_state_nxt = DBG_IDLE;
      end
      default: w_state_nxt = DBG_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_status   <= '0;
    end else begin
      case (r_state)
        DBG_IDLE: if (w_rx_hs) begin
          r_cnt      <= '0;
          r_addr     <= '0;
          r_wdata    <= '0;
          r_is_write <= (rx_data_i == DbgOpWrite);
          r_status   <= DbgStsBadOp;
        end
        DBG_ADDR, DBG_DATA: if (w_tmo) begin
          r_cnt    <= '0;
          r_addr   <= '0;
          r_wdata  <= '0;
          r_status <= DbgStsTimeout;
        end else if (w_rx_hs) begin
          r_cnt <= r_cnt + 2'd1;
          if (r_state == DBG_ADDR) r_addr[{r_cnt, 3'b000} +: 8]  <= w_addr_byte;
          else                     r_wdata[{r_cnt, 3'b000} +: 8] <= rx_data_i;
        end
        // rvalid is only meaningful here; anything seen in other states is stale.
        DBG_RSP: if (obi_rsp_i.rvalid) begin
          r_rdata  <= obi_rsp_i.r.rdata;
          r_status <= obi_rsp_i.r.err ? DbgStsErr : DbgStsOk;
          r_cnt    <= '0;
        end
        DBG_TX_DATA: if (w_tx_hs) r_cnt <= r_cnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
